// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Two-core snooping bus arbiter. Each L1 controller raises a level request
// together with a command and line address. The arbiter picks one owner,
// broadcasts the owner's command/address for one cycle (with a snoop strobe to
// the other core), holds the grant until the L2/memory side pulses done, then
// spends one RELEASE cycle with no grant before arbitrating again.
// Contention is resolved round-robin against the last released owner.
//
// FSM: IDLE -> GRANT -> WAIT -> RELEASE -> IDLE. Every output is a flop.
//
// Optional feature (compile-time macro ARB_TIMEOUT_EN):
//   Adds a WAIT-state watchdog. If done does not arrive within TIMEOUT WAIT
//   cycles the transaction is force-released and the sticky timeout_err flag
//   is set until reset. Without the macro WAIT lasts until done and
//   timeout_err is a constant 0.
//
// Parameters:
//   ADDR_W   address width
//   TIMEOUT  watchdog limit in WAIT cycles (only meaningful with ARB_TIMEOUT_EN)
//
// Ports:
//   clk                       clock, all logic on rising edge
//   reset                     asynchronous active-low reset
//   req_core0 / req_core1     level bus requests
//   cmd_core0 / cmd_core1     0=NONE 1=BusRd 2=BusRdX 3=BusUpgr
//   addr_core0 / addr_core1   request line addresses
//   done                      one-cycle completion strobe
//   grant_core0 / grant_core1 bus ownership, one-hot or zero
//   bus_valid                 one-cycle broadcast valid (GRANT cycle)
//   bus_cmd / bus_addr        latched command/address of the owner
//   bus_owner                 index of the owning core
//   snoop_core0 / snoop_core1 one-cycle snoop strobe to the non-owner
//   timeout_err               sticky watchdog flag
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_core0,
    input  logic              req_core1,
    input  logic [1:0]        cmd_core0,
    input  logic [1:0]        cmd_core1,
    input  logic [ADDR_W-1:0] addr_core0,
    input  logic [ADDR_W-1:0] addr_core1,
    input  logic              done,
    output logic              grant_core0,
    output logic              grant_core1,
    output logic              bus_valid,
    output logic [1:0]        bus_cmd,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_owner,
    output logic              snoop_core0,
    output logic              snoop_core1,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_last_owner;
    logic                r_grant_core0;
    logic                r_grant_core1;
    logic                r_bus_valid;
    logic [1:0]          r_bus_cmd;
    logic [ADDR_W-1:0]   r_bus_addr;
    logic                r_bus_owner;
    logic                r_snoop_core0;
    logic                r_snoop_core1;

    logic                w_any_req;
    logic                w_winner;
    logic [1:0]          w_win_cmd;
    logic [ADDR_W-1:0]   w_win_addr;

`ifdef ARB_TIMEOUT_EN
    // Counter must be able to hold TIMEOUT-1, the value seen in the last
    // permitted WAIT cycle.
    localparam int           CNT_W        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0]    r_wait_cnt;
    logic                r_timeout_err;
`endif

    // Winner selection: a lone requester wins; on contention the core that
    // did not own the bus last time wins.
    always_comb begin
        w_any_req  = req_core0 | req_core1;
        w_winner   = 1'b0;
        if (req_core0 && req_core1) begin
            w_winner = ~r_last_owner;
        end else if (req_core1) begin
            w_winner = 1'b1;
        end else begin
            w_winner = 1'b0;
        end
        if (w_winner) begin
            w_win_cmd  = cmd_core1;
            w_win_addr = addr_core1;
        end else begin
            w_win_cmd  = cmd_core0;
            w_win_addr = addr_core0;
        end
    end

    // Arbitration FSM with all bus-side outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_last_owner  <= 1'b1;
            r_grant_core0 <= 1'b0;
            r_grant_core1 <= 1'b0;
            r_bus_valid   <= 1'b0;
            r_bus_cmd     <= 2'd0;
            r_bus_addr    <= '0;
            r_bus_owner   <= 1'b0;
            r_snoop_core0 <= 1'b0;
            r_snoop_core1 <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // done is meaningless here and is not looked at.
                    if (w_any_req) begin
                        r_state       <= ST_GRANT;
                        r_grant_core0 <= ~w_winner;
                        r_grant_core1 <= w_winner;
                        r_bus_valid   <= 1'b1;
                        r_bus_cmd     <= w_win_cmd;
                        r_bus_addr    <= w_win_addr;
                        r_bus_owner   <= w_winner;
                        r_snoop_core0 <= w_winner;
                        r_snoop_core1 <= ~w_winner;
                    end else begin
                        r_state       <= ST_IDLE;
                        r_bus_valid   <= 1'b0;
                        r_snoop_core0 <= 1'b0;
                        r_snoop_core1 <= 1'b0;
                    end
                end

                ST_GRANT: begin
                    // Broadcast lasts exactly one cycle; done is ignored here
                    // because the transaction has not been issued yet.
                    r_state       <= ST_WAIT;
                    r_bus_valid   <= 1'b0;
                    r_snoop_core0 <= 1'b0;
                    r_snoop_core1 <= 1'b0;
`ifdef ARB_TIMEOUT_EN
                    r_wait_cnt    <= '0;
`endif
                end

                ST_WAIT: begin
                    // Grant is held regardless of the request level; only
                    // done (or the watchdog) ends ownership.
                    r_bus_valid   <= 1'b0;
                    r_snoop_core0 <= 1'b0;
                    r_snoop_core1 <= 1'b0;
                    if (done) begin
                        r_state       <= ST_RELEASE;
                        r_grant_core0 <= 1'b0;
                        r_grant_core1 <= 1'b0;
                        r_last_owner  <= r_bus_owner;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (r_wait_cnt >= CNT_LAST) begin
                        r_state       <= ST_RELEASE;
                        r_grant_core0 <= 1'b0;
                        r_grant_core1 <= 1'b0;
                        r_last_owner  <= r_bus_owner;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_state       <= ST_WAIT;
                        r_wait_cnt    <= r_wait_cnt + CNT_W'(1);
                    end
`else
                    else begin
                        r_state       <= ST_WAIT;
                    end
`endif
                end

                ST_RELEASE: begin
                    // Dead cycle between owners; done and requests ignored.
                    r_state       <= ST_IDLE;
                    r_grant_core0 <= 1'b0;
                    r_grant_core1 <= 1'b0;
                    r_bus_valid   <= 1'b0;
                    r_snoop_core0 <= 1'b0;
                    r_snoop_core1 <= 1'b0;
                end

                default: begin
                    r_state       <= ST_IDLE;
                    r_grant_core0 <= 1'b0;
                    r_grant_core1 <= 1'b0;
                    r_bus_valid   <= 1'b0;
                    r_snoop_core0 <= 1'b0;
                    r_snoop_core1 <= 1'b0;
                end
            endcase
        end
    end

    assign grant_core0 = r_grant_core0;
    assign grant_core1 = r_grant_core1;
    assign bus_valid   = r_bus_valid;
    assign bus_cmd     = r_bus_cmd;
    assign bus_addr    = r_bus_addr;
    assign bus_owner   = r_bus_owner;
    assign snoop_core0 = r_snoop_core0;
    assign snoop_core1 = r_snoop_core1;

`ifdef ARB_TIMEOUT_EN
    assign timeout_err = r_timeout_err;
`else
    // TIMEOUT has no effect in this build; referencing it keeps the parameter
    // list identical between builds without leaving it dangling.
    assign timeout_err = (TIMEOUT >= 0) ? 1'b0 : 1'b0;
`endif

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width.
REQ-002 SHALL have parameter TIMEOUT, default 15: watchdog limit in cycles (used only with ARB_TIMEOUT_EN).
REQ-003 SHALL have port: clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: req_core0 / req_core1  input  1  level bus request from each L1 controller.
REQ-006 SHALL have ports: cmd_core0 / cmd_core1  input  2  0=NONE, 1=BusRd, 2=BusRdX, 3=BusUpgr.
REQ-007 SHALL have ports: addr_core0 / addr_core1  input  ADDR_W  request line address.
REQ-008 SHALL have port: done  input  1  one-cycle completion strobe from L2/memory side.
REQ-009 SHALL have ports: grant_core0 / grant_core1  output  1  bus ownership, one-hot or zero.
REQ-010 SHALL have ports: bus_valid  output  1; bus_cmd  output  2; bus_addr  output  ADDR_W; bus_owner  output  1  broadcast transaction.
REQ-011 SHALL have ports: snoop_core0 / snoop_core1  output  1  snoop strobe to the non-owning core.
REQ-012 SHALL have port: timeout_err  output  1  sticky watchdog flag (tied 0 without ARB_TIMEOUT_EN).

Function
REQ-013 SHALL implement FSM IDLE -> GRANT -> WAIT -> RELEASE -> IDLE, all outputs registered.
REQ-014 IDLE: if any req sampled high at edge N, SHALL enter GRANT with grant_coreX high from cycle N+1; otherwise stay IDLE.
REQ-015 Single requester SHALL win; both requesting SHALL grant the core != last_owner (round-robin).
REQ-016 On entering GRANT SHALL latch winner's cmd/addr; bus_valid, bus_cmd, bus_addr, bus_owner and the non-owner's snoop strobe SHALL be valid for exactly that one cycle.
REQ-017 bus_cmd/bus_addr SHALL hold the latched values until RELEASE; inputs changing after grant SHALL be ignored.
REQ-018 GRANT SHALL go to WAIT unconditionally; done during GRANT SHALL be ignored.
REQ-019 WAIT: done high SHALL move to RELEASE; grant held throughout WAIT regardless of req level.
REQ-020 RELEASE: grants SHALL be 0, last_owner SHALL update to the released owner; next state IDLE.
REQ-021 Minimum back-to-back spacing: done at edge M -> next grant earliest at M+3.
REQ-022 done in IDLE or RELEASE SHALL be ignored; no state change.
REQ-023 grant_core0 and grant_core1 SHALL never be high simultaneously.
REQ-024 A request with cmd=NONE SHALL still be arbitrated and broadcast (bus_cmd=0).

Reset
REQ-025 reset low SHALL asynchronously force IDLE, all grants/bus_valid/snoops/timeout_err to 0, bus_cmd=0, bus_addr=0, bus_owner=0.
REQ-026 last_owner SHALL reset to 1 so core0 wins the first contended arbitration.
REQ-027 reset asserted mid-transaction SHALL drop the grant immediately; no RELEASE cycle is produced.

Configuration
REQ-028 Macro ARB_TIMEOUT_EN SHALL compile in a WAIT-state cycle counter.
REQ-029 With ARB_TIMEOUT_EN: counter clears on entering WAIT; if it reaches TIMEOUT without done, SHALL go to RELEASE, set timeout_err (sticky until reset); done on the same cycle takes priority and does not set the flag.
REQ-030 Without ARB_TIMEOUT_EN: WAIT SHALL persist indefinitely until done; timeout_err constant 0, no counter logic.

Verification
REQ-031 Reset release, req_core1=1, cmd=2, addr=0x1000 at edge 1 -> grant_core1=1 cycle 2, bus_valid=1, bus_cmd=2, bus_addr=0x1000, bus_owner=1, snoop_core0=1 for one cycle.
REQ-032 Both req high from reset -> core0 granted first; done -> RELEASE; both still high -> core1 granted 3 cycles after done.
REQ-033 During core0 WAIT, addr_core0 changes 0x40->0x80 and req_core0 drops -> bus_addr stays 0x40, grant_core0 stays 1 until done.
REQ-034 reset low during WAIT -> grant_core0=0 same cycle, FSM IDLE, timeout_err=0.
REQ-035 ARB_TIMEOUT_EN, TIMEOUT=15, no done -> RELEASE after 15 WAIT cycles, timeout_err=1 and remains 1 across later transactions until reset.
REQ-036 done pulsed in IDLE with no requests -> all outputs remain 0, FSM stays IDLE.
